// File: rtl/axis_scheduler_if.sv
// axis_scheduler_if: job, stream-beat and config bus bundle for axis_scheduler
// slave  : scheduler side (takes jobs and beats; drives job_ready, cfg_*, done/busy/err)
// master : client side (offers jobs and beats; observes the rest)
interface axis_scheduler_if #(parameter int AW = 5, parameter int DW = 32);
  logic wr_job_valid, wr_job_ready, rd_job_valid, rd_job_ready;
  logic [DW-1:0] wr_job_addr, wr_job_len, rd_job_addr, rd_job_len;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic cfg_valid, wr_beat, rd_beat, wr_done, rd_done, wr_busy, rd_busy, wr_err, rd_err;
  modport slave (
    input  wr_job_valid, wr_job_addr, wr_job_len, rd_job_valid, rd_job_addr, rd_job_len, wr_beat, rd_beat,
    output wr_job_ready, rd_job_ready, cfg_addr, cfg_data, cfg_valid, wr_done, rd_done, wr_busy, rd_busy, wr_err, rd_err
  );
  modport master (
    output wr_job_valid, wr_job_addr, wr_job_len, rd_job_valid, rd_job_addr, rd_job_len, wr_beat, rd_beat,
    input  wr_job_ready, rd_job_ready, cfg_addr, cfg_data, cfg_valid, wr_done, rd_done, wr_busy, rd_busy, wr_err, rd_err
  );
endinterface

// File: rtl/axis_scheduler.sv
// axis_scheduler: serialises write/read jobs into 3-word cfg sequences and tracks their stream beats
// clk : rising-edge clock
// rst : asynchronous active-low reset
// bus : axis_scheduler_if.slave (jobs in, cfg words out, beats in, done/busy/err out)
module axis_scheduler #(
  parameter int CONFIG_AWIDTH = 5,
  parameter int CONFIG_DWIDTH = 32,
  parameter logic [CONFIG_AWIDTH-1:0] CONFIG_ID_WR = CONFIG_AWIDTH'(1),
  parameter logic [CONFIG_AWIDTH-1:0] CONFIG_ID_RD = CONFIG_AWIDTH'(2),
  parameter logic [CONFIG_AWIDTH-1:0] CONFIG_ADDR = CONFIG_AWIDTH'(23),
  parameter logic [CONFIG_AWIDTH-1:0] CONFIG_DATA = CONFIG_AWIDTH'(24)
) (
  input logic clk,
  input logic rst,
  axis_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PEND, ACTIVE} path_t;
  typedef enum logic [1:0] {C_IDLE, C_ADDR, C_LEN, C_START} cfg_t;
  path_t ps [2];
  cfg_t cs;
  logic gnt, arb_sel;
  logic [1:0] vld, beat, req, done_q, err_q;
  logic [1:0][CONFIG_DWIDTH-1:0] a_in, l_in, addr_q, len_q, rem;
  assign vld  = {bus.rd_job_valid, bus.wr_job_valid};
  assign beat = {bus.rd_beat, bus.wr_beat};
  assign a_in = {bus.rd_job_addr, bus.wr_job_addr};
  assign l_in = {bus.rd_job_len, bus.wr_job_len};
  // The path whose START word is on the bus is still PEND but must not be re-granted;
  // excluding it lets the other path's sequence follow with no idle cycle.
  assign req[0] = ps[0] == PEND && !(cs == C_START && !gnt);
  assign req[1] = ps[1] == PEND && !(cs == C_START && gnt);
  // gnt holds the last granted path, so on contention the other one wins
  assign arb_sel = &req ? !gnt : req[1];
  assign bus.wr_job_ready = ps[0] == IDLE;
  assign bus.rd_job_ready = ps[1] == IDLE;
  assign bus.wr_busy = ps[0] != IDLE;
  assign bus.rd_busy = ps[1] != IDLE;
  assign bus.wr_done = done_q[0];
  assign bus.rd_done = done_q[1];
  assign bus.wr_err = err_q[0];
  assign bus.rd_err = err_q[1];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cs <= C_IDLE;
      gnt <= 1'b1;
      bus.cfg_valid <= 1'b0;
      bus.cfg_addr <= '0;
      bus.cfg_data <= '0;
    end else begin
      case (cs)
        C_ADDR: begin
          cs <= C_LEN;
          bus.cfg_addr <= CONFIG_DATA;
          bus.cfg_data <= len_q[gnt];
        end
        C_LEN: begin
          cs <= C_START;
          bus.cfg_addr <= gnt ? CONFIG_ID_RD : CONFIG_ID_WR;
          bus.cfg_data <= CONFIG_DWIDTH'(1);
        end
        default: begin
          cs <= |req ? C_ADDR : C_IDLE;
          bus.cfg_valid <= |req;
          bus.cfg_addr <= |req ? CONFIG_ADDR : '0;
          bus.cfg_data <= |req ? addr_q[arb_sel] : '0;
          if (|req) gnt <= arb_sel;
        end
      endcase
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < 2; i++) ps[i] <= IDLE;
      addr_q <= '0;
      len_q <= '0;
      rem <= '0;
      done_q <= '0;
      err_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        err_q[i] <= err_q[i] | (beat[i] && ps[i] != ACTIVE);
        done_q[i] <= 1'b0;
        case (ps[i])
          IDLE: if (vld[i]) begin
            addr_q[i] <= a_in[i];
            len_q[i] <= l_in[i];
            if (l_in[i] == '0) done_q[i] <= 1'b1;
            else ps[i] <= PEND;
          end
          PEND: if (cs == C_START && gnt == 1'(i)) begin
            ps[i] <= ACTIVE;
            rem[i] <= len_q[i];
          end
          ACTIVE: if (beat[i]) begin
            rem[i] <= rem[i] - 1'b1;
            if (rem[i] == CONFIG_DWIDTH'(1)) begin
              ps[i] <= IDLE;
              done_q[i] <= 1'b1;
            end
          end
          default: ps[i] <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_axis_scheduler.sv
// tb_axis_scheduler: randomized + directed bench with a timestamp-based reference model and scoreboard
module tb_axis_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  axis_scheduler_if #(.AW(5), .DW(32)) bus ();
  axis_scheduler dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int c; logic [4:0] a; logic [31:0] d;} cw_t;
  cw_t cfg_q[$];
  int done_q[2][$];
  int ph[2];
  int acc[2];
  int act[2];
  int phb[2];
  logic [31:0] ma[2], ml[2], rem_m[2];
  bit merr[2];
  int last, seq_until, k, w;
  logic [1:0] v, b, dn, rdy, bsy, er, c;
  cw_t e;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  task automatic model_reset();
    cfg_q.delete();
    for (int p = 0; p < 2; p++) begin
      done_q[p].delete();
      ph[p] = 0;
      merr[p] = 0;
    end
    last = 1;
    seq_until = -100;
  endtask

  // Monitor: the model knows a job becomes a grant candidate two cycles after acceptance,
  // that a sequence occupies three cycles, and that counting starts the cycle after START.
  initial begin : monitor
    model_reset();
    forever begin
      @(negedge clk);
      #1;
      k = cyc;
      v = {bus.rd_job_valid, bus.wr_job_valid};
      b = {bus.rd_beat, bus.wr_beat};
      dn = {bus.rd_done, bus.wr_done};
      rdy = {bus.rd_job_ready, bus.wr_job_ready};
      bsy = {bus.rd_busy, bus.wr_busy};
      er = {bus.rd_err, bus.wr_err};
      if (!rst) begin
        model_reset();
        chk("rst_cfg_valid", bus.cfg_valid, 0);
        chk("rst_cfg_addr", bus.cfg_addr, 0);
        chk("rst_cfg_data", bus.cfg_data, 0);
        chk("rst_ready", rdy, 2'b11);
        chk("rst_busy", bsy, 0);
        chk("rst_done", dn, 0);
        chk("rst_err", er, 0);
      end else begin
        if (k > seq_until) begin
          c[0] = ph[0] == 1 && acc[0] <= k - 2;
          c[1] = ph[1] == 1 && acc[1] <= k - 2;
          if (c != 2'b00) begin
            w = (c == 2'b11) ? 1 - last : (c[1] ? 1 : 0);
            last = w;
            cfg_q.push_back('{k, 5'd23, ma[w]});
            cfg_q.push_back('{k + 1, 5'd24, ml[w]});
            cfg_q.push_back('{k + 2, (w == 1) ? 5'd2 : 5'd1, 32'd1});
            ph[w] = 2;
            act[w] = k + 3;
            rem_m[w] = ml[w];
            seq_until = k + 2;
          end
        end
        if (bus.cfg_valid) begin
          if (cfg_q.size() == 0) chk("cfg_unexpected", 1, 0);
          else begin
            e = cfg_q.pop_front();
            chk("cfg_cycle", k, e.c);
            chk("cfg_addr", bus.cfg_addr, e.a);
            chk("cfg_data", bus.cfg_data, e.d);
          end
        end else if (cfg_q.size() > 0 && cfg_q[0].c <= k) begin
          chk("cfg_valid_missing", bus.cfg_valid, 1);
          void'(cfg_q.pop_front());
        end
        for (int p = 0; p < 2; p++) begin
          if (dn[p]) begin
            if (done_q[p].size() == 0) chk(p ? "rd_done_unexpected" : "wr_done_unexpected", 1, 0);
            else chk(p ? "rd_done_cycle" : "wr_done_cycle", k, done_q[p].pop_front());
          end else if (done_q[p].size() > 0 && done_q[p][0] <= k) begin
            chk(p ? "rd_done_missing" : "wr_done_missing", dn[p], 1);
            void'(done_q[p].pop_front());
          end
          chk(p ? "rd_ready" : "wr_ready", rdy[p], ph[p] == 0);
          chk(p ? "rd_busy" : "wr_busy", bsy[p], ph[p] != 0);
          chk(p ? "rd_err" : "wr_err", er[p], merr[p]);
          phb[p] = ph[p];
        end
        for (int p = 0; p < 2; p++) begin
          if (b[p]) begin
            if (phb[p] == 2 && k >= act[p]) begin
              rem_m[p] = rem_m[p] - 1;
              if (rem_m[p] == 0) begin
                ph[p] = 0;
                done_q[p].push_back(k + 1);
              end
            end else merr[p] = 1;
          end
          if (phb[p] == 0 && v[p]) begin
            if ((p ? bus.rd_job_len : bus.wr_job_len) == 0) done_q[p].push_back(k + 1);
            else begin
              ph[p] = 1;
              acc[p] = k;
              ma[p] = p ? bus.rd_job_addr : bus.wr_job_addr;
              ml[p] = p ? bus.rd_job_len : bus.wr_job_len;
            end
          end
        end
      end
    end
  end

  task automatic drive(input bit wv, input bit rv, input bit wb, input bit rb,
                       input logic [31:0] wa, input logic [31:0] wl, input logic [31:0] ra, input logic [31:0] rl);
    @(negedge clk);
    bus.wr_job_valid = wv;
    bus.rd_job_valid = rv;
    bus.wr_beat = wb;
    bus.rd_beat = rb;
    bus.wr_job_addr = wa;
    bus.wr_job_len = wl;
    bus.rd_job_addr = ra;
    bus.rd_job_len = rl;
  endtask

  task automatic run(input int n, input bit wb, input bit rb);
    repeat (n) drive(0, 0, wb, rb, 0, 0, 0, 0);
  endtask

  initial begin : stimulus
    bus.wr_job_valid = 0;
    bus.rd_job_valid = 0;
    bus.wr_beat = 0;
    bus.rd_beat = 0;
    bus.wr_job_addr = 0;
    bus.wr_job_len = 0;
    bus.rd_job_addr = 0;
    bus.rd_job_len = 0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    run(2, 0, 0);
    // single write job, beats every cycle from ACTIVE
    drive(1, 0, 0, 0, 32'h1000_0000, 8, 0, 0);
    run(4, 0, 0);
    run(8, 1, 0);
    run(3, 0, 0);
    // simultaneous write and read jobs
    drive(1, 1, 0, 0, 32'h0000_2000, 4, 32'h0000_3000, 4);
    run(4, 0, 0);
    run(3, 1, 0);
    run(1, 1, 1);
    run(3, 0, 1);
    run(2, 0, 0);
    // repeated contention: grants alternate
    repeat (4) begin
      drive(1, 1, 0, 0, $urandom, 1, $urandom, 1);
      run(4, 0, 0);
      run(1, 1, 0);
      run(2, 0, 0);
      run(1, 0, 1);
      run(1, 0, 0);
    end
    // zero-length read, second read accepted the very next cycle
    drive(0, 1, 0, 0, 0, 0, 32'h0000_4000, 0);
    drive(0, 1, 0, 0, 0, 0, 32'h0000_5000, 2);
    run(4, 0, 0);
    run(2, 0, 1);
    run(2, 0, 0);
    // stray beat while idle, then a normal job
    run(1, 1, 0);
    drive(1, 0, 0, 0, 32'h0000_6000, 3, 0, 0);
    run(4, 0, 0);
    run(3, 1, 0);
    run(2, 0, 0);
    // reset during C_LEN, then contention must favour write again
    drive(1, 0, 0, 0, 32'h0000_7000, 5, 0, 0);
    run(2, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.wr_job_valid = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive(1, 1, 0, 0, 32'h0000_8000, 2, 32'h0000_9000, 2);
    run(4, 0, 0);
    run(2, 1, 0);
    run(1, 0, 0);
    run(2, 0, 1);
    run(2, 0, 0);
    // randomized traffic
    for (int i = 0; i < 1500; i++)
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
            $urandom, $urandom_range(0, 6), $urandom, $urandom_range(0, 6));
    run(40, 1, 1);
    run(3, 0, 0);
    chk("cfg_left", cfg_q.size(), 0);
    chk("wr_done_left", done_q[0].size(), 0);
    chk("rd_done_left", done_q[1].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_scheduler.md
# axis_scheduler

Job scheduler that sits in front of the `axis` block and owns its shared configuration bus. It accepts independent write-path and read-path jobs (base address and length in stream words). It serialises each job into an atomic three-word configuration sequence, arbitrating round-robin when both paths are waiting. It then tracks stream beats to signal per-path job completion.

## Interface
- CONFIG_ID_WR, 1, cfg address that commits a write job
- CONFIG_ID_RD, 2, cfg address that commits a read job
- CONFIG_ADDR, 23, cfg address carrying job base address
- CONFIG_DATA, 24, cfg address carrying job length
- CONFIG_AWIDTH, 5, cfg address width
- CONFIG_DWIDTH, 32, cfg data, job address and job length width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- wr_job_valid  in  1  write job offered
- wr_job_addr  in  CONFIG_DWIDTH  write job base byte address
- wr_job_len  in  CONFIG_DWIDTH  write job length in stream words
- wr_job_ready  out  1  write path idle, job accepted on valid&ready
- rd_job_valid, rd_job_addr, rd_job_len, rd_job_ready: same as the write-job ports, for the read path
- cfg_addr  out  CONFIG_AWIDTH  config address to `axis`
- cfg_data  out  CONFIG_DWIDTH  config data to `axis`
- cfg_valid  out  1  config word valid; no backpressure
- wr_beat  in  1  one write-stream word transferred (wr_valid&wr_ready)
- rd_beat  in  1  one read-stream word transferred (rd_valid&rd_ready)
- wr_done, rd_done  out  1  one-cycle job-complete pulse
- wr_busy, rd_busy  out  1  path state is not IDLE
- wr_err, rd_err  out  1  sticky: beat seen while path not ACTIVE

## Operation
- Path FSM (one per path): IDLE -> PEND on job accept. PEND -> ACTIVE at the edge that ends its START cfg word. ACTIVE -> IDLE at the edge where beat && remaining==1.
- On accept, addr and len are latched. `job_ready` = (state==IDLE).
- Zero-length job: accepted, no cfg traffic; path goes IDLE -> IDLE and `done` pulses the next cycle.
- Cfg FSM: C_IDLE -> C_ADDR -> C_LEN -> C_START -> C_IDLE, one word per cycle with `cfg_valid`=1:
  - C_ADDR: cfg_addr=CONFIG_ADDR, cfg_data=addr.
  - C_LEN: cfg_addr=CONFIG_DATA, cfg_data=len.
  - C_START: cfg_addr=CONFIG_ID_WR or CONFIG_ID_RD, cfg_data=1.
- A sequence is never interleaved with the other path.
- Arbitration happens in C_IDLE among paths in PEND:
  - Single requester wins.
  - If both request, the one not granted last wins.
  - After reset, write has priority.
- Granted path is registered; grant-to-C_ADDR takes one cycle.
- Remaining counter is loaded with len at the START edge and decrements on each beat in ACTIVE. Width is CONFIG_DWIDTH; no wrap (a beat at remaining==1 ends the job).
- `done` is registered and high for exactly the cycle the path re-enters IDLE. `job_ready` is also high in that cycle, so back-to-back jobs lose no cycle.
- Beat while IDLE or PEND: beat is ignored, `err` is set; `err` clears only on reset.
- Simultaneous job accept on both paths: both latch; write is granted first (or per round-robin pointer).

## Timing
- Reset values:
  - Path and cfg FSMs: IDLE / C_IDLE.
  - job_ready=1.
  - cfg_valid=0, cfg_addr=0, cfg_data=0.
  - done, busy, err = 0.
  - Round-robin pointer favours write.
- Accept at edge T (both FSMs idle):
  - PEND and busy=1 from T+1.
  - Grant at edge T+2; C_ADDR, C_LEN, C_START on cycles T+2, T+3, T+4.
  - ACTIVE from T+5; beats are counted from cycle T+5.
- Last beat in cycle N: done=1 and job_ready=1 in cycle N+1; busy=0 in N+1.
- Other path blocked by a sequence in progress: it waits in PEND; its C_ADDR starts the cycle after the running C_START.
- Reset asserted mid-sequence or mid-job: all state is dropped immediately. Jobs are lost; the caller must re-issue.
- All outputs are registered except job_ready and busy (decoded from state registers).

## Test plan
- Write job addr=0x1000_0000, len=8, beats every cycle from ACTIVE -> cfg words (23,0x1000_0000), (24,8), (1,1) on T+2..T+4; wr_done one cycle after the 8th beat; rd_* untouched.
- Write and read jobs accepted in the same cycle (len 4 each) -> write sequence on cycles 2..4, read sequence on cycles 5..7 with ID 2; both dones arrive after their 4th beats.
- Repeated simultaneous pending -> grants alternate W,R,W,R; no back-to-back grant to one path while the other is pending.
- Zero-length read job -> no cfg_valid; rd_done pulses at T+1; a second job is accepted at T+1.
- Beat with path IDLE, then a job -> wr_err=1 stays set; the job still completes normally with the correct count.
- Reset pulled low during C_LEN -> cfg_valid=0 immediately, job_ready=1, busy=0; a new job after release behaves as a fresh reset (write priority).
